vector_sequencer: RTL and testbench

VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

---
 rtl/vector_sequencer.sv | 114 +++++++++++
 tb/tb_vector_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_sequencer.sv
// Vector sequencer: applies all 32 five-bit test vectors to a combinational
// circuit under test, holds each for HOLD cycles, and compacts the sampled
// OutF/OutG responses into a 16-bit MISR signature.
module vector_sequencer #(
    parameter int HOLD = 10
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start,
    input  logic        Abort,
    input  logic        InF,
    input  logic        InG,
    output logic        OutA,
    output logic        OutB,
    output logic        OutC,
    output logic        OutD,
    output logic        OutE,
    output logic [4:0]  VecIdx,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Signature
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Last hold-counter value before a sample is taken
    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t      state;
    logic [7:0]  holdCnt;
    logic [4:0]  vecIdx;
    logic [15:0] sig;
    logic        busyQ;
    logic        doneQ;

    // One MISR step: shift in the feedback tap, then fold the two responses
    // into the two low-order bits.
    function automatic logic [15:0] misrNext(input logic [15:0] cur,
                                             input logic       f,
                                             input logic       g);
        logic fb;
        fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
        return {cur[14:0], fb} ^ {14'b0, g, f};
    endfunction

    // Sequencer FSM with registered Busy/Done flags kept in step with state
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= IDLE;
            holdCnt <= 8'd0;
            vecIdx  <= 5'd0;
            sig     <= 16'h0000;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Abort outranks Start; results of the last sweep stay visible
                    if (Start && !Abort) begin
                        state   <= APPLY;
                        holdCnt <= 8'd0;
                        vecIdx  <= 5'd0;
                        sig     <= 16'h0000;
                        busyQ   <= 1'b1;
                        doneQ   <= 1'b0;
                    end
                end
                APPLY: begin
                    if (Abort) begin
                        // Leave without sampling; signature and index are kept
                        state <= IDLE;
                        busyQ <= 1'b0;
                        doneQ <= 1'b0;
                    end else if (holdCnt == HOLD_LAST) begin
                        sig     <= misrNext(sig, InF, InG);
                        holdCnt <= 8'd0;
                        if (vecIdx == 5'd31) begin
                            state <= DONE;
                            busyQ <= 1'b0;
                            doneQ <= 1'b1;
                        end else begin
                            vecIdx <= vecIdx + 5'd1;
                        end
                    end else begin
                        holdCnt <= holdCnt + 8'd1;
                    end
                end
                DONE: begin
                    // Single-cycle completion pulse; Start and Abort are ignored
                    state <= IDLE;
                    busyQ <= 1'b0;
                    doneQ <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busyQ <= 1'b0;
                    doneQ <= 1'b0;
                end
            endcase
        end
    end

    // Stimulus pins mirror the vector index register, OutA is the MSB
    assign {OutA, OutB, OutC, OutD, OutE} = vecIdx;
    assign VecIdx    = vecIdx;
    assign Busy      = busyQ;
    assign Done      = doneQ;
    assign Signature = sig;

endmodule

// File: tb/tb_vector_sequencer.sv
// Testbench for vector_sequencer: three instances (HOLD = 2, 1, 10) share a
// clock and reset; a small combinational CUT model closes the loop.
module tb_vector_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN;
    logic useCut, drvF, drvG;

    // Index 0: HOLD=2, index 1: HOLD=1, index 2: HOLD=10
    logic        start [3];
    logic        abort [3];
    logic        inF   [3];
    logic        inG   [3];
    logic        oa    [3];
    logic        ob    [3];
    logic        oc    [3];
    logic        od    [3];
    logic        oe    [3];
    logic [4:0]  vec   [3];
    logic        busy  [3];
    logic        done  [3];
    logic [15:0] sig   [3];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0] vec;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t        obsQ [$];
    logic [15:0] sigQ [$];

    vector_sequencer #(.HOLD(2)) dut2 (
        .Clock(clk), .Resetn(rstN), .Start(start[0]), .Abort(abort[0]),
        .InF(inF[0]), .InG(inG[0]),
        .OutA(oa[0]), .OutB(ob[0]), .OutC(oc[0]), .OutD(od[0]), .OutE(oe[0]),
        .VecIdx(vec[0]), .Busy(busy[0]), .Done(done[0]), .Signature(sig[0])
    );

    vector_sequencer #(.HOLD(1)) dut1 (
        .Clock(clk), .Resetn(rstN), .Start(start[1]), .Abort(abort[1]),
        .InF(inF[1]), .InG(inG[1]),
        .OutA(oa[1]), .OutB(ob[1]), .OutC(oc[1]), .OutD(od[1]), .OutE(oe[1]),
        .VecIdx(vec[1]), .Busy(busy[1]), .Done(done[1]), .Signature(sig[1])
    );

    vector_sequencer #(.HOLD(10)) dut10 (
        .Clock(clk), .Resetn(rstN), .Start(start[2]), .Abort(abort[2]),
        .InF(inF[2]), .InG(inG[2]),
        .OutA(oa[2]), .OutB(ob[2]), .OutC(oc[2]), .OutD(od[2]), .OutE(oe[2]),
        .VecIdx(vec[2]), .Busy(busy[2]), .Done(done[2]), .Signature(sig[2])
    );

    // Circuit under test, inputs {A,B,C,D,E} with A as MSB
    function automatic logic cutF(input logic [4:0] v);
        return (v[4] & v[3]) | (v[2] ^ v[1] ^ v[0]);
    endfunction

    function automatic logic cutG(input logic [4:0] v);
        return (~(v[4] | v[0])) ^ (v[3] & v[2] & v[1]);
    endfunction

    function automatic logic [15:0] misrModel(input logic [15:0] s,
                                              input logic f, input logic g);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb} ^ {14'b0, g, f};
    endfunction

    function automatic logic [15:0] goldenSig();
        logic [15:0] s;
        logic [4:0]  v;
        s = 16'h0000;
        for (int k = 0; k < 32; k++) begin
            v = 5'(k);
            s = misrModel(s, cutF(v), cutG(v));
        end
        return s;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            inF[i] = drvF;
            inG[i] = drvG;
            if (useCut) begin
                inF[i] = cutF({oa[i], ob[i], oc[i], od[i], oe[i]});
                inG[i] = cutG({oa[i], ob[i], oc[i], od[i], oe[i]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        rstN = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({oa[i], ob[i], oc[i], od[i], oe[i], vec[i], busy[i], done[i], sig[i]} !== 28'h0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got vec=%h busy=%b done=%b sig=%h, expected all zero",
                         i, vec[i], busy[i], done[i], sig[i]);
            end
        end
        rstN = 1'b1;
        tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        n = 0;
        while (vec[0] !== 5'd7 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (vec[0] !== 5'd7) begin
            errors++;
            $display("FAIL reset_reach_vec7: got vec=%0d, expected 7", vec[0]);
        end
        // Assert reset mid-cycle, no clock edge in between
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if ({oa[0], ob[0], oc[0], od[0], oe[0], vec[0], busy[0], done[0], sig[0]} !== 28'h0) begin
            errors++;
            $display("FAIL reset_async: got vec=%h busy=%b done=%b sig=%h, expected all zero",
                     vec[0], busy[0], done[0], sig[0]);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (done[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done: got done=%b, expected 0", done[0]);
            end
        end
        rstN = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_stays_idle: got busy=%b done=%b, expected 0 0", busy[0], done[0]);
            end
        end
    endtask

    task automatic test_full_sweep();
        obs_t e, got;
        useCut = 1'b0;
        drvF = 1'b0;
        drvG = 1'b0;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int n = 0; n <= 65; n++) begin
            if (n < 64)       e = '{vec: 5'(n / 2), busy: 1'b1, done: 1'b0};
            else if (n == 64) e = '{vec: 5'd31, busy: 1'b0, done: 1'b1};
            else              e = '{vec: 5'd31, busy: 1'b0, done: 1'b0};
            obsQ.push_back(e);
        end
        for (int n = 0; n <= 65; n++) begin
            if (n > 0) tick();
            e = obsQ.pop_front();
            got = '{vec: vec[0], busy: busy[0], done: done[0]};
            checks++;
            if (got !== e || {oa[0], ob[0], oc[0], od[0], oe[0]} !== e.vec) begin
                errors++;
                $display("FAIL sweep_cycle%0d: got vec=%0d pins=%b busy=%b done=%b, expected vec=%0d busy=%b done=%b",
                         n, got.vec, {oa[0], ob[0], oc[0], od[0], oe[0]}, got.busy, got.done,
                         e.vec, e.busy, e.done);
            end
        end
        checks++;
        if (sig[0] !== 16'h0000) begin
            errors++;
            $display("FAIL sweep_signature: got %h, expected 0000", sig[0]);
        end
    endtask

    task automatic test_misr();
        logic [15:0] e;
        useCut = 1'b0;
        drvF = 1'b1;
        drvG = 1'b0;
        sigQ.push_back(16'h0001);
        sigQ.push_back(16'h0003);
        sigQ.push_back(16'h0007);
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        checks++;
        if (sig[1] !== 16'h0000 || busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL misr_start: got sig=%h busy=%b, expected 0000 1", sig[1], busy[1]);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            e = sigQ.pop_front();
            checks++;
            if (sig[1] !== e) begin
                errors++;
                $display("FAIL misr_sample%0d: got %h, expected %h", k, sig[1], e);
            end
        end
    endtask

    // Continues from test_misr: three samples taken, vector 3 applied
    task automatic test_abort();
        abort[1] = 1'b1;
        tick();
        abort[1] = 1'b0;
        checks++;
        if (busy[1] !== 1'b0 || done[1] !== 1'b0 || sig[1] !== 16'h0007 || vec[1] !== 5'd3) begin
            errors++;
            $display("FAIL abort_edge: got busy=%b done=%b sig=%h vec=%0d, expected 0 0 0007 3",
                     busy[1], done[1], sig[1], vec[1]);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (done[1] !== 1'b0 || busy[1] !== 1'b0 || sig[1] !== 16'h0007) begin
                errors++;
                $display("FAIL abort_hold: got busy=%b done=%b sig=%h, expected 0 0 0007",
                         busy[1], done[1], sig[1]);
            end
        end
    endtask

    task automatic test_start_abort_idle();
        start[1] = 1'b1;
        abort[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        abort[1] = 1'b0;
        checks++;
        if (busy[1] !== 1'b0 || sig[1] !== 16'h0007 || vec[1] !== 5'd3) begin
            errors++;
            $display("FAIL start_abort_idle: got busy=%b sig=%h vec=%0d, expected 0 0007 3",
                     busy[1], sig[1], vec[1]);
        end
        tick();
        checks++;
        if (busy[1] !== 1'b0 || sig[1] !== 16'h0007) begin
            errors++;
            $display("FAIL start_abort_after: got busy=%b sig=%h, expected 0 0007", busy[1], sig[1]);
        end
    endtask

    task automatic test_ignored_start();
        int cnt;
        logic [15:0] gold;
        gold = goldenSig();
        useCut = 1'b1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        cnt = 0;
        while (vec[0] !== 5'd10 && cnt < 100) begin
            tick();
            cnt++;
        end
        start[0] = 1'b1;
        tick();
        cnt++;
        start[0] = 1'b0;
        checks++;
        if (vec[0] !== 5'(cnt / 2) || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL ignored_start_restart: got vec=%0d busy=%b, expected %0d 1",
                     vec[0], busy[0], cnt / 2);
        end
        while (done[0] !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt !== 64) begin
            errors++;
            $display("FAIL ignored_start_latency: got done after %0d edges, expected 64", cnt);
        end
        checks++;
        if (sig[0] !== gold) begin
            errors++;
            $display("FAIL ignored_start_sig: got %h, expected %h", sig[0], gold);
        end
    endtask

    task automatic test_cut();
        int cnt;
        logic [15:0] s, gold, e;
        logic [4:0] v;
        useCut = 1'b1;
        gold = goldenSig();
        s = 16'h0000;
        for (int k = 0; k < 32; k++) begin
            v = 5'(k);
            s = misrModel(s, cutF(v), cutG(v));
            sigQ.push_back(s);
        end
        start[1] = 1'b1;
        start[2] = 1'b1;
        tick();
        start[1] = 1'b0;
        start[2] = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            cnt++;
            e = sigQ.pop_front();
            checks++;
            if (sig[1] !== e) begin
                errors++;
                $display("FAIL cut_hold1_sample%0d: got %h, expected %h", k, sig[1], e);
            end
        end
        checks++;
        if (done[1] !== 1'b1) begin
            errors++;
            $display("FAIL cut_hold1_done: got done=%b, expected 1", done[1]);
        end
        // Abort while in DONE has no effect on completion
        abort[1] = 1'b1;
        tick();
        cnt++;
        abort[1] = 1'b0;
        checks++;
        if (done[1] !== 1'b0 || busy[1] !== 1'b0 || sig[1] !== gold) begin
            errors++;
            $display("FAIL cut_abort_in_done: got done=%b busy=%b sig=%h, expected 0 0 %h",
                     done[1], busy[1], sig[1], gold);
        end
        while (done[2] !== 1'b1 && cnt < 400) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt !== 320) begin
            errors++;
            $display("FAIL cut_hold10_latency: got done after %0d edges, expected 320", cnt);
        end
        checks++;
        if (sig[2] !== gold) begin
            errors++;
            $display("FAIL cut_hold10_sig: got %h, expected %h", sig[2], gold);
        end
        checks++;
        if (sig[2] !== sig[1]) begin
            errors++;
            $display("FAIL cut_sig_match: got hold10=%h hold1=%h, expected equal", sig[2], sig[1]);
        end
        tick();
        checks++;
        if (done[2] !== 1'b0 || busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL cut_hold10_idle: got done=%b busy=%b, expected 0 0", done[2], busy[2]);
        end
    endtask

    initial begin
        useCut = 1'b0;
        drvF = 1'b0;
        drvG = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            abort[i] = 1'b0;
        end
        test_reset();
        test_full_sweep();
        test_misr();
        test_abort();
        test_start_abort_idle();
        test_ignored_start();
        test_cut();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
